// File: rtl/ibex_rvfi_trace_buffer.sv
// On-chip RVFI retirement trace buffer: circular store with fill-stop or overwrite capture,
// valid/ready readout of the oldest record, saturating drop counter and sticky wrap flag.
module ibex_rvfi_trace_buffer #(
    parameter int unsigned Depth    = 16,
    parameter int unsigned CntWidth = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [1:0]                 trace_mode_i,
    input  logic                       trace_clear_i,
    input  logic                       rvfi_valid,
    input  logic [31:0]                rvfi_pc_rdata,
    input  logic [31:0]                rvfi_insn,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic [31:0]                rvfi_rd_wdata,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_intr,
    input  logic [1:0]                 rvfi_mode,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [31:0]                rd_pc_o,
    output logic [31:0]                rd_insn_o,
    output logic [4:0]                 rd_rd_addr_o,
    output logic [31:0]                rd_rd_wdata_o,
    output logic [3:0]                 rd_flags_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic [CntWidth-1:0]        drop_cnt_o,
    output logic                       wrapped_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned LW = $clog2(Depth) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [3:0]  flags;
    } rec_t;

    rec_t mem [Depth];

    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [CntWidth-1:0] drop_q, drop_d;
    logic                wrapped_q, wrapped_d;
    logic                mem_we_c;
    logic                push_req_c, pop_c, full_c;
    rec_t                wr_rec_c, head_c;

    assign wr_rec_c = '{pc:       rvfi_pc_rdata,
                        insn:     rvfi_insn,
                        rd_addr:  rvfi_rd_addr,
                        rd_wdata: rvfi_rd_wdata,
                        flags:    {rvfi_trap, rvfi_intr, rvfi_mode}};

    // Next-state: clear beats everything; a push with a pop never drops, even when full.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_d     = drop_q;
        wrapped_d  = wrapped_q;
        mem_we_c   = 1'b0;
        push_req_c = rvfi_valid && ((trace_mode_i == 2'd1) || (trace_mode_i == 2'd2));
        pop_c      = (level_q != '0) && rd_ready_i;
        full_c     = (level_q == LW'(Depth));

        if (trace_clear_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            drop_d    = '0;
            wrapped_d = 1'b0;
        end else if (push_req_c) begin
            if (pop_c) begin
                mem_we_c = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else if (!full_c) begin
                mem_we_c = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                level_d  = level_q + LW'(1);
            end else begin
                if (drop_q != {CntWidth{1'b1}}) begin
                    drop_d = drop_q + CntWidth'(1);
                end
                if (trace_mode_i == 2'd2) begin
                    // Full in circular mode: tail equals head, so the oldest record is replaced.
                    mem_we_c  = 1'b1;
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    wrapped_d = 1'b1;
                end
            end
        end else if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            drop_q    <= '0;
            wrapped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            drop_q    <= drop_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Record storage carries no reset; empty-state outputs are masked below instead.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem[wr_ptr_q] <= wr_rec_c;
        end
    end

    assign head_c        = mem[rd_ptr_q];
    assign rd_valid_o    = (level_q != '0);
    assign rd_pc_o       = rd_valid_o ? head_c.pc       : '0;
    assign rd_insn_o     = rd_valid_o ? head_c.insn     : '0;
    assign rd_rd_addr_o  = rd_valid_o ? head_c.rd_addr  : '0;
    assign rd_rd_wdata_o = rd_valid_o ? head_c.rd_wdata : '0;
    assign rd_flags_o    = rd_valid_o ? head_c.flags    : '0;
    assign level_o       = level_q;
    assign drop_cnt_o    = drop_q;
    assign wrapped_o     = wrapped_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for ibex_rvfi_trace_buffer: vector table plus hand sequences for
// fill-stop, circular overwrite, clear priority, counter saturation and async reset.
module tb_ibex_rvfi_trace_buffer;

    localparam int unsigned Depth = 16;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  trace_mode_i;
    logic        trace_clear_i;
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata;
    logic [31:0] rvfi_insn;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata;
    logic        rvfi_trap;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic        rd_ready_i;

    logic        rd_valid_o;
    logic [31:0] rd_pc_o, rd_insn_o, rd_rd_wdata_o;
    logic [4:0]  rd_rd_addr_o;
    logic [3:0]  rd_flags_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        wrapped_o;

    logic        sat_valid;
    logic [31:0] sat_pc, sat_insn, sat_wdata;
    logic [4:0]  sat_addr;
    logic [3:0]  sat_flags;
    logic [4:0]  sat_level;
    logic [1:0]  sat_drop;
    logic        sat_wrapped;

    int errors;
    int checks;

    ibex_rvfi_trace_buffer #(.Depth(Depth), .CntWidth(16)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .trace_mode_i(trace_mode_i), .trace_clear_i(trace_clear_i),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_pc_o(rd_pc_o), .rd_insn_o(rd_insn_o), .rd_rd_addr_o(rd_rd_addr_o),
        .rd_rd_wdata_o(rd_rd_wdata_o), .rd_flags_o(rd_flags_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .wrapped_o(wrapped_o)
    );

    ibex_rvfi_trace_buffer #(.Depth(Depth), .CntWidth(2)) u_sat (
        .clk_i(clk_i), .rst_ni(rst_ni), .trace_mode_i(trace_mode_i), .trace_clear_i(trace_clear_i),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rd_valid_o(sat_valid), .rd_ready_i(rd_ready_i),
        .rd_pc_o(sat_pc), .rd_insn_o(sat_insn), .rd_rd_addr_o(sat_addr),
        .rd_rd_wdata_o(sat_wdata), .rd_flags_o(sat_flags), .level_o(sat_level),
        .drop_cnt_o(sat_drop), .wrapped_o(sat_wrapped)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  mode;
        logic        valid;
        logic [31:0] pc;
        logic        ready;
        logic        clear;
        int          exp_level;
        logic [31:0] exp_pc;
        int          exp_drop;
        logic        exp_wrapped;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Other record fields are derived from the pc so a single value identifies a whole record.
    function automatic logic [72:0] rec_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013, pc[6:2], ~pc, pc[2], pc[3], pc[5:4]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input logic [1:0] m, input logic v, input logic [31:0] pc,
                       input logic r, input logic c);
        trace_mode_i  = m;
        rvfi_valid    = v;
        rvfi_pc_rdata = pc;
        rvfi_insn     = {pc[15:0], 16'h0013};
        rvfi_rd_addr  = pc[6:2];
        rvfi_rd_wdata = ~pc;
        rvfi_trap     = pc[2];
        rvfi_intr     = pc[3];
        rvfi_mode     = pc[5:4];
        rd_ready_i    = r;
        trace_clear_i = c;
        tick();
    endtask

    task automatic check_status(input string name, input int lvl, input int drop, input logic wr);
        chk({name, "_level"}, 128'(level_o), 128'(lvl));
        chk({name, "_valid"}, 128'(rd_valid_o), 128'(lvl != 0));
        chk({name, "_drop"}, 128'(drop_cnt_o), 128'(drop));
        chk({name, "_wrapped"}, 128'(wrapped_o), 128'(wr));
    endtask

    task automatic check_head(input string name, input logic [31:0] pc);
        chk({name, "_pc"}, 128'(rd_pc_o), 128'(pc));
        chk({name, "_rec"}, 128'({rd_insn_o, rd_rd_addr_o, rd_rd_wdata_o, rd_flags_o}), 128'(rec_of(pc)));
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vt[0]  = '{2'd1, 1'b1, 32'h100, 1'b0, 1'b0, 1, 32'h100, 0, 1'b0};
        vt[1]  = '{2'd1, 1'b1, 32'h104, 1'b0, 1'b0, 2, 32'h100, 0, 1'b0};
        vt[2]  = '{2'd1, 1'b1, 32'h108, 1'b0, 1'b0, 3, 32'h100, 0, 1'b0};
        vt[3]  = '{2'd1, 1'b0, 32'h0,   1'b1, 1'b0, 2, 32'h104, 0, 1'b0};
        vt[4]  = '{2'd1, 1'b0, 32'h0,   1'b1, 1'b0, 1, 32'h108, 0, 1'b0};
        vt[5]  = '{2'd1, 1'b0, 32'h0,   1'b1, 1'b0, 0, 32'h0,   0, 1'b0};
        vt[6]  = '{2'd1, 1'b0, 32'h0,   1'b1, 1'b0, 0, 32'h0,   0, 1'b0};
        vt[7]  = '{2'd0, 1'b1, 32'h10c, 1'b0, 1'b0, 0, 32'h0,   0, 1'b0};
        vt[8]  = '{2'd3, 1'b1, 32'h110, 1'b0, 1'b0, 0, 32'h0,   0, 1'b0};
        vt[9]  = '{2'd0, 1'b1, 32'h114, 1'b1, 1'b0, 0, 32'h0,   0, 1'b0};
        vt[10] = '{2'd1, 1'b1, 32'h120, 1'b0, 1'b0, 1, 32'h120, 0, 1'b0};
        vt[11] = '{2'd0, 1'b1, 32'h124, 1'b0, 1'b0, 1, 32'h120, 0, 1'b0};
        vt[12] = '{2'd0, 1'b0, 32'h0,   1'b1, 1'b0, 0, 32'h0,   0, 1'b0};

        rst_ni = 1'b0;
        trace_mode_i = 2'd0; trace_clear_i = 1'b0; rvfi_valid = 1'b0; rvfi_pc_rdata = '0;
        rvfi_insn = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_trap = 1'b0;
        rvfi_intr = 1'b0; rvfi_mode = '0; rd_ready_i = 1'b0;
        #12;
        check_status("reset", 0, 0, 1'b0);
        chk("reset_pc", 128'(rd_pc_o), 128'(0));
        chk("reset_rec", 128'({rd_insn_o, rd_rd_addr_o, rd_rd_wdata_o, rd_flags_o}), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        for (int k = 0; k < 13; k++) begin
            cyc(vt[k].mode, vt[k].valid, vt[k].pc, vt[k].ready, vt[k].clear);
            check_status($sformatf("vec%0d", k), vt[k].exp_level, vt[k].exp_drop, vt[k].exp_wrapped);
            chk($sformatf("vec%0d_pc", k), 128'(rd_pc_o), 128'(vt[k].exp_pc));
            if (vt[k].exp_level != 0) begin
                check_head($sformatf("vec%0d_head", k), vt[k].exp_pc);
            end
        end

        // Fill-stop: overflow is dropped and counted; the 2-bit counter saturates.
        cyc(2'd1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(2'd1, 1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        check_status("fs_full", 16, 4, 1'b0);
        check_head("fs_full_head", 32'h200);
        chk("sat_drop_a", 128'(sat_drop), 128'(3));
        chk("sat_level", 128'(sat_level), 128'(16));
        chk("sat_valid", 128'(sat_valid), 128'(1));
        chk("sat_rec", 128'({sat_pc, sat_insn, sat_addr, sat_wdata, sat_flags, sat_wrapped}),
            128'({32'h200, rec_of(32'h200), 1'b0}));
        for (int i = 0; i < 2; i++) cyc(2'd1, 1'b1, 32'h280 + 32'(4 * i), 1'b0, 1'b0);
        check_status("fs_more", 16, 6, 1'b0);
        chk("sat_drop_b", 128'(sat_drop), 128'(3));
        cyc(2'd1, 1'b1, 32'h2000, 1'b1, 1'b0);
        check_status("fs_pushpop", 16, 6, 1'b0);
        check_head("fs_pushpop_head", 32'h204);
        for (int i = 0; i < 16; i++) begin
            check_head($sformatf("fs_drain%0d", i), (i < 15) ? 32'h204 + 32'(4 * i) : 32'h2000);
            cyc(2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check_status("fs_empty", 0, 6, 1'b0);

        // Circular: overflow replaces the oldest records and sets the sticky flag.
        cyc(2'd2, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(2'd2, 1'b1, 32'(4 * i), 1'b0, 1'b0);
        check_status("cir_full", 16, 4, 1'b1);
        check_head("cir_full_head", 32'h10);
        cyc(2'd2, 1'b1, 32'h1000, 1'b1, 1'b0);
        check_status("cir_pushpop", 16, 4, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check_head($sformatf("cir_drain%0d", i), (i < 15) ? 32'h14 + 32'(4 * i) : 32'h1000);
            cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        check_status("cir_empty", 0, 4, 1'b1);

        // Clear wins over a simultaneous push and pop.
        for (int i = 0; i < 5; i++) cyc(2'd2, 1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        check_status("clr_pre", 5, 4, 1'b1);
        cyc(2'd2, 1'b1, 32'h600, 1'b1, 1'b1);
        check_status("clr_post", 0, 0, 1'b0);
        chk("clr_pc", 128'(rd_pc_o), 128'(0));
        cyc(2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
        check_status("clr_after", 0, 0, 1'b0);

        // Asynchronous reset in the middle of a drain, between clock edges.
        for (int i = 0; i < 18; i++) cyc(2'd2, 1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
        cyc(2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc(2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        check_status("ar_pre", 14, 2, 1'b1);
        check_head("ar_pre_head", 32'h710);
        #2;
        rst_ni = 1'b0;
        #1;
        check_status("ar_async", 0, 0, 1'b0);
        chk("ar_rec", 128'({rd_pc_o, rd_insn_o, rd_rd_addr_o, rd_rd_wdata_o, rd_flags_o}), 128'(0));
        chk("ar_sat_drop", 128'(sat_drop), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(2'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_status("ar_after", 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
